// File: rtl/ring_if.sv
// Buzzer driver bus: alarm request and BCD time in, bell drive and ownership flags out.
interface ring_if;
    logic       ALARM;
    logic [7:0] TIME_M;
    logic [7:0] TIME_S;
    logic       BELL;
    logic       ALARM_ACT;
    logic       CHIME_ACT;

    modport master (output ALARM, TIME_M, TIME_S, input BELL, ALARM_ACT, CHIME_ACT);
    modport slave  (input ALARM, TIME_M, TIME_S, output BELL, ALARM_ACT, CHIME_ACT);
endinterface

// File: rtl/ring_driver.sv
// Alarm beeper / hourly chime buzzer driver clocked by CP (nominally 1024 Hz).
// Define CHIME_EN to build the hourly chime (59:51..59:59); otherwise only the alarm ring exists.
module ring_driver #(
    parameter int DIV_HALF_S = 512
) (
    input  logic CP,
    input  logic CR,
    ring_if.slave bus
);
    localparam int BW = $clog2(DIV_HALF_S) + 1;
    localparam logic [BW-1:0] HALF = BW'(DIV_HALF_S);
    localparam logic [BW-1:0] LAST = BW'(2 * DIV_HALF_S - 1);

`ifdef CHIME_EN
    typedef enum logic [1:0] {IDLE, CHIME_LO, CHIME_HI, RING} state_t;
`else
    typedef enum logic {IDLE, RING} state_t;
`endif

    state_t        state_q, state_d;
    logic [1:0]    div_q, div_d;
    logic [BW-1:0] bcnt_q, bcnt_d, bcnt_cur;
    logic          bell_q, bell_d;
    logic          aact_q, aact_d;
    logic          cact_q, cact_d;

`ifdef CHIME_EN
    logic hr_m, chime_lo, chime_hi;
    // Exact BCD compares, so non-BCD time values can never match.
    assign hr_m     = (bus.TIME_M == 8'h59);
    assign chime_hi = hr_m && (bus.TIME_S == 8'h59);
    assign chime_lo = hr_m && (bus.TIME_S inside {8'h51, 8'h53, 8'h55, 8'h57});
`else
    logic unused_time;
    assign unused_time = ^{bus.TIME_M, bus.TIME_S};
`endif

    always_comb begin
        div_d   = div_q + 2'd1;
        state_d = bus.ALARM ? RING : IDLE;
`ifdef CHIME_EN
        if (chime_hi)      state_d = CHIME_HI;
        else if (chime_lo) state_d = CHIME_LO;
`endif
        bcnt_d   = bcnt_q;
        bcnt_cur = (state_q == IDLE) ? '0 : bcnt_q;
        bell_d   = 1'b0;
        aact_d   = 1'b0;
        cact_d   = 1'b0;
        // Outputs are computed from the next state so they line up with state_q.
        case (state_d)
            RING: begin
                aact_d = 1'b1;
                bell_d = (bcnt_cur < HALF) && div_d[0];
                bcnt_d = (bcnt_cur == LAST) ? '0 : bcnt_cur + 1'b1;
            end
`ifdef CHIME_EN
            // Beat count is held here so a preempted ring resumes in phase.
            CHIME_LO: begin
                cact_d = 1'b1;
                bell_d = div_d[1];
            end
            CHIME_HI: begin
                cact_d = 1'b1;
                bell_d = div_d[0];
            end
`endif
            IDLE:    bcnt_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q <= IDLE;
            div_q   <= '0;
            bcnt_q  <= '0;
            bell_q  <= 1'b0;
            aact_q  <= 1'b0;
            cact_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bcnt_q  <= bcnt_d;
            bell_q  <= bell_d;
            aact_q  <= aact_d;
            cact_q  <= cact_d;
        end
    end

    assign bus.BELL      = bell_q;
    assign bus.ALARM_ACT = aact_q;
`ifdef CHIME_EN
    assign bus.CHIME_ACT = cact_q;
`else
    assign bus.CHIME_ACT = 1'b0;
    logic unused_cact;
    assign unused_cact = cact_q;
`endif
endmodule

// File: tb/tb_ring_driver.sv
// Directed bench for ring_driver: vector table plus multi-cycle ring/chime/reset sequences.
module tb_ring_driver;
    localparam int MI = 0, MR = 1, ML = 2, MH = 3;
    localparam int HS = 512;
`ifdef CHIME_EN
    localparam bit CHB = 1'b1;
`else
    localparam bit CHB = 1'b0;
`endif

    logic CP = 1'b0;
    logic CR = 1'b1;
    logic [31:0] ncyc;
    int ncmp = 0;
    int nbad = 0;

    ring_if bus ();
    ring_driver #(.DIV_HALF_S(HS)) dut (.CP(CP), .CR(CR), .bus(bus));

    always #5 CP = ~CP;

    // Edges since reset release: the free-running divider phase seen by the bell.
    always @(posedge CP or posedge CR) begin
        if (CR) ncyc <= 32'd0;
        else    ncyc <= ncyc + 32'd1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       al;
        logic [7:0] tm;
        logic [7:0] ts;
        int         md_ch;
        int         md_nc;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic act, input logic exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            if (nbad <= 20) $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic drive(input logic al, input logic [7:0] tm, input logic [7:0] ts);
        bus.ALARM  = al;
        bus.TIME_M = tm;
        bus.TIME_S = ts;
    endtask

    // Expected BELL for a mode; c is the beat count of a RING cycle.
    function automatic logic exp_bell(input int md, input int c);
        case (md)
            MR:      return ((c % (2 * HS)) < HS) ? ncyc[0] : 1'b0;
            ML:      return ncyc[1];
            MH:      return ncyc[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk_mode(input string nm, input int md, input int c);
        chk({nm, ".bell"}, bus.BELL, exp_bell(md, c));
        chk({nm, ".aact"}, bus.ALARM_ACT, md == MR);
        chk({nm, ".cact"}, bus.CHIME_ACT, md == ML || md == MH);
    endtask

    initial begin
        int md;
        tbl[0]  = '{1'b0, 8'h00, 8'h00, MI, MI};
        tbl[1]  = '{1'b1, 8'h00, 8'h00, MR, MR};
        tbl[2]  = '{1'b1, 8'h12, 8'h34, MR, MR};
        tbl[3]  = '{1'b1, 8'h59, 8'h51, ML, MR};
        tbl[4]  = '{1'b1, 8'h59, 8'h52, MR, MR};
        tbl[5]  = '{1'b0, 8'h59, 8'h53, ML, MI};
        tbl[6]  = '{1'b0, 8'h59, 8'h59, MH, MI};
        tbl[7]  = '{1'b1, 8'h59, 8'h59, MH, MR};
        tbl[8]  = '{1'b0, 8'h59, 8'h5A, MI, MI};
        tbl[9]  = '{1'b0, 8'h5A, 8'h51, MI, MI};
        tbl[10] = '{1'b0, 8'h58, 8'h59, MI, MI};
        tbl[11] = '{1'b1, 8'h59, 8'h50, MR, MR};
        tbl[12] = '{1'b0, 8'h00, 8'h00, MI, MI};

        // Reset holds everything quiet even with active inputs.
        drive(1'b1, 8'h59, 8'h59);
        CR = 1'b1;
        repeat (3) tick();
        chk_mode("reset", MI, 0);
        drive(1'b0, 8'h00, 8'h00);
        @(negedge CP);
        CR = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].al, tbl[i].tm, tbl[i].ts);
            tick();
            md = CHB ? tbl[i].md_ch : tbl[i].md_nc;
            chk_mode($sformatf("vec%0d", i), md, 0);
        end

        // Two full beat periods of ringing from a fresh entry.
        drive(1'b1, 8'h00, 8'h00);
        for (int k = 0; k < 4 * HS; k++) begin
            tick();
            chk_mode("beat", MR, k);
        end
        drive(1'b0, 8'h00, 8'h00);
        tick();
        chk_mode("beat_off", MI, 0);

        // Alarm drop 100 cycles in: silent one cycle later.
        drive(1'b1, 8'h00, 8'h00);
        repeat (100) tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        chk_mode("drop100", MI, 0);

        // Async reset mid-ring, alarm held: silent at once, ring restarts after release.
        drive(1'b1, 8'h00, 8'h00);
        repeat (5) tick();
        if (!ncyc[0]) tick();
        chk("cr.bell_pre", bus.BELL, 1'b1);
        #2 CR = 1'b1;
        #1;
        chk("cr.bell_async", bus.BELL, 1'b0);
        chk("cr.aact_async", bus.ALARM_ACT, 1'b0);
        @(negedge CP);
        CR = 1'b0;
        tick();
        chk_mode("cr.reenter", MR, 0);

`ifdef CHIME_EN
        drive(1'b0, 8'h00, 8'h00);
        tick();
        for (int s = 51; s <= 59; s++) begin
            drive(1'b0, 8'h59, {4'd5, 4'(s - 50)});
            md = (s == 59) ? MH : ((s % 2) == 1 ? ML : MI);
            for (int k = 0; k < 2 * HS; k++) begin
                tick();
                chk($sformatf("chime%0d.cact", s), bus.CHIME_ACT, md != MI);
                chk($sformatf("chime%0d.bell", s), bus.BELL, exp_bell(md, 0));
            end
        end

        // Chime preempts ring; ring resumes at the frozen beat count.
        drive(1'b0, 8'h00, 8'h00);
        tick();
        drive(1'b1, 8'h59, 8'h56);
        for (int k = 0; k < 300; k++) begin
            tick();
            chk_mode("pre.ring", MR, k);
        end
        drive(1'b1, 8'h59, 8'h57);
        for (int k = 0; k < 500; k++) begin
            tick();
            chk_mode("pre.chime", ML, 0);
        end
        drive(1'b1, 8'h59, 8'h58);
        for (int k = 0; k < 600; k++) begin
            tick();
            chk_mode("pre.resume", MR, 300 + k);
        end
`else
        drive(1'b0, 8'h59, 8'h59);
        for (int k = 0; k < 2000; k++) begin
            tick();
            chk("nochime.bell", bus.BELL, 1'b0);
            chk("nochime.cact", bus.CHIME_ACT, 1'b0);
        end
        drive(1'b1, 8'h59, 8'h57);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk_mode("nochime.ring", MR, k);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
